timer_apb_slave: RTL and testbench

- APB slave and register file in front of the timer core (counter and compare logic).
- Decodes the bus, holds control registers, and returns 0 for reserved and unmapped locations.
- Drives control, compare, interrupt-enable and halt signals to the core.
- Takes the counter value, compare-match pulse and halt acknowledge back from the core.

---
 rtl/timer_apb_slave.sv | 145 ++++++++++++++
 tb/tb_timer_apb_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_slave.sv
// APB slave and register file for the timer core: bus FSM, control/compare registers, interrupt status.
// Optional build macro TIMER_PSLVERR_EN enables error responses for unmapped accesses and rejected TCR writes.
module timer_apb_slave #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    input  logic [63:0] cnt_val,
    input  logic        cmp_match,
    input  logic        halt_ack,
    output logic        tdr0_wr,
    output logic        tdr1_wr,
    output logic [31:0] tdr_wdata,
    output logic        timer_en,
    output logic        div_en,
    output logic [3:0]  div_val,
    output logic [63:0] tcmp,
    output logic        halt_req,
    output logic        tim_int
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYC - 1);

    state_t state, state_nxt;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] addr;
    logic              mapped;
    logic              wr_en;
    logic              tier;
    logic              tisr;
    logic              div_bad;
    logic              tcr_lock;
    logic [31:0]       rdata;
    logic              unused_paddr;

    assign addr         = paddr[ADDR_W-1:0];
    assign unused_paddr = ^paddr;
    assign mapped       = (addr[1:0] == 2'b00) && (addr[ADDR_W-1:5] == '0);
    assign wr_en        = (state == RESP) && psel && pwrite && mapped;

    // A TCR write may not change the divider while the timer is running.
    assign div_bad  = (pwdata[11:8] > 4'd8);
    assign tcr_lock = timer_en && ((pwdata[1] != div_en) || (pwdata[11:8] != div_val));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (psel && penable) state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
            WAIT: begin
                if (!psel)                      state_nxt = IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer_en  <= 1'b0;
            div_en    <= 1'b0;
            div_val   <= 4'd1;
            tcmp      <= '1;
            tier      <= 1'b0;
            tisr      <= 1'b0;
            halt_req  <= 1'b0;
            tim_int   <= 1'b0;
            tdr0_wr   <= 1'b0;
            tdr1_wr   <= 1'b0;
            tdr_wdata <= '0;
        end else begin
            tdr0_wr <= wr_en && (addr[4:2] == 3'd1);
            tdr1_wr <= wr_en && (addr[4:2] == 3'd2);
            if (wr_en) tdr_wdata <= pwdata;
            if (wr_en) begin
                case (addr[4:2])
                    3'd0: begin
                        timer_en <= pwdata[0];
                        if (!tcr_lock) begin
                            div_en <= pwdata[1];
                            if (!div_bad) div_val <= pwdata[11:8];
                        end
                    end
                    3'd3:    tcmp[31:0]  <= pwdata;
                    3'd4:    tcmp[63:32] <= pwdata;
                    3'd5:    tier        <= pwdata[0];
                    3'd7:    halt_req    <= pwdata[0];
                    default: ;
                endcase
            end
            // A compare hit in the same cycle as a clear keeps the flag set.
            tisr    <= cmp_match || (tisr && !(wr_en && (addr[4:2] == 3'd6) && pwdata[0]));
            tim_int <= tisr && tier;
        end
    end

    always_comb begin
        rdata = '0;
        if (mapped) begin
            case (addr[4:2])
                3'd0: rdata = {20'd0, div_val, 6'd0, div_en, timer_en};
                3'd1: rdata = cnt_val[31:0];
                3'd2: rdata = cnt_val[63:32];
                3'd3: rdata = tcmp[31:0];
                3'd4: rdata = tcmp[63:32];
                3'd5: rdata = {31'd0, tier};
                3'd6: rdata = {31'd0, tisr};
                3'd7: rdata = {30'd0, halt_ack, halt_req};
                default: rdata = '0;
            endcase
        end
    end

    assign pready = (state == RESP);
    assign prdata = (state == RESP) ? rdata : 32'd0;

`ifdef TIMER_PSLVERR_EN
    assign pslverr = (state == RESP) &&
                     (!mapped || (pwrite && (addr[4:2] == 3'd0) && div_bad));
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed self-checking bench for timer_apb_slave (default WAIT_CYC=1).
module tb_timer_apb_slave;

`ifdef TIMER_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [63:0] cnt_val;
    logic        cmp_match, halt_ack;
    logic        tdr0_wr, tdr1_wr;
    logic [31:0] tdr_wdata;
    logic        timer_en, div_en;
    logic [3:0]  div_val;
    logic [63:0] tcmp;
    logic        halt_req, tim_int;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic        cmp_on_resp = 1'b0;
    logic        post_tdr0, post_tdr1, post_pready;
    logic [31:0] post_wdata;
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        seen;

    timer_apb_slave #(.ADDR_W(12), .WAIT_CYC(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .cnt_val(cnt_val), .cmp_match(cmp_match), .halt_ack(halt_ack),
        .tdr0_wr(tdr0_wr), .tdr1_wr(tdr1_wr), .tdr_wdata(tdr_wdata),
        .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
        .tcmp(tcmp), .halt_req(halt_req), .tim_int(tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdv, output logic errv, output int latv);
        logic done;
        done = 1'b0; rdv = '0; errv = 1'b0; latv = 0;
        @(posedge sys_clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        for (int i = 1; i <= 10 && !done; i++) begin
            @(posedge sys_clk); #1;
            if (pready) begin
                done = 1'b1; latv = i; rdv = prdata; errv = pslverr;
                if (cmp_on_resp) cmp_match = 1'b1;
            end
        end
        check("pready_seen", {63'd0, done}, 64'd1);
        @(posedge sys_clk); #1;
        cmp_match = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        post_tdr0 = tdr0_wr; post_tdr1 = tdr1_wr; post_wdata = tdr_wdata; post_pready = pready;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic exp_err);
        logic [31:0] r; logic e; int l;
        apb(1'b1, addr, wd, r, e, l);
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_rd,
                           input logic exp_err);
        logic [31:0] r; logic e; int l;
        apb(1'b0, addr, 32'd0, r, e, l);
        check(tag, {32'd0, r}, {32'd0, exp_rd});
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    initial begin
        sys_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; cnt_val = '0; cmp_match = 1'b0; halt_ack = 1'b0;
        #1;
        check("rst_pready", {63'd0, pready}, 64'd0);
        check("rst_prdata", {32'd0, prdata}, 64'd0);
        check("rst_pslverr", {63'd0, pslverr}, 64'd0);
        check("rst_strobes", {62'd0, tdr0_wr, tdr1_wr}, 64'd0);
        check("rst_tcr_out", {58'd0, div_val, div_en, timer_en}, 64'h4);
        check("rst_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_halt_int", {62'd0, halt_req, tim_int}, 64'd0);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Reset values through the bus, plus response timing
        apb(1'b0, 32'h0, 32'd0, rd, err, lat);
        check("rd_tcr", {32'd0, rd}, 64'h100);
        check("latency", lat, 64'd2);
        check("pready_one_cycle", {63'd0, post_pready}, 64'd0);
        do_read("rd_tdr0", 32'h04, 32'h0, 1'b0);
        do_read("rd_tdr1", 32'h08, 32'h0, 1'b0);
        do_read("rd_tcmp0", 32'h0C, 32'hFFFF_FFFF, 1'b0);
        do_read("rd_tcmp1", 32'h10, 32'hFFFF_FFFF, 1'b0);
        do_read("rd_tier", 32'h14, 32'h0, 1'b0);
        do_read("rd_tisr", 32'h18, 32'h0, 1'b0);
        do_read("rd_thcsr", 32'h1C, 32'h0, 1'b0);

        // Unmapped and unaligned addresses
        do_write("wr_unal", 32'h0000_00AA, 32'h1234_ABCD, ERR_EN);
        do_write("wr_hi", 32'h4000_1FFC, 32'h1234_ABCD, ERR_EN);
        do_write("wr_20", 32'h0000_0020, 32'h1234_ABCD, ERR_EN);
        do_read("rd_unal", 32'h0000_00AA, 32'h0, ERR_EN);
        do_read("rd_hi", 32'h4000_1FFC, 32'h0, ERR_EN);
        do_read("rd_20", 32'h0000_0020, 32'h0, ERR_EN);
        do_read("rd_tcr_after_unmapped", 32'h0, 32'h100, 1'b0);
        check("tcmp_after_unmapped", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);

        // TCR divider protection
        do_write("wr_tcr_901", 32'h0, 32'h0000_0901, ERR_EN);
        do_read("rd_tcr_101", 32'h0, 32'h0000_0101, 1'b0);
        check("tcr_out_101", {58'd0, div_val, div_en, timer_en}, 64'h5);
        do_write("wr_tcr_303", 32'h0, 32'h0000_0303, 1'b0);
        do_read("rd_tcr_locked", 32'h0, 32'h0000_0101, 1'b0);

        // Counter load strobes and live counter readback
        do_write("wr_tdr0", 32'h04, 32'h5555_AAAA, 1'b0);
        check("tdr0_pulse", {62'd0, post_tdr0, post_tdr1}, 64'h2);
        check("tdr_wdata", {32'd0, post_wdata}, 64'h5555_AAAA);
        @(posedge sys_clk); #1;
        check("tdr0_single", {63'd0, tdr0_wr}, 64'd0);
        cnt_val = 64'h1_0000_0002;
        do_read("rd_tdr1_live", 32'h08, 32'h1, 1'b0);
        do_read("rd_tdr0_live", 32'h04, 32'h2, 1'b0);

        // Compare registers
        do_write("wr_tcmp0", 32'h0C, 32'h1111_2222, 1'b0);
        do_write("wr_tcmp1", 32'h10, 32'h3333_4444, 1'b0);
        check("tcmp_out", tcmp, 64'h3333_4444_1111_2222);

        // Interrupt status and enable
        do_write("wr_tier", 32'h14, 32'h1, 1'b0);
        @(posedge sys_clk); #1; cmp_match = 1'b1;
        @(posedge sys_clk); #1; cmp_match = 1'b0;
        @(posedge sys_clk); #1;
        check("tim_int_set", {63'd0, tim_int}, 64'd1);
        do_read("rd_tisr_set", 32'h18, 32'h1, 1'b0);
        cmp_on_resp = 1'b1;
        do_write("wr_tisr_race", 32'h18, 32'h1, 1'b0);
        cmp_on_resp = 1'b0;
        do_read("rd_tisr_race", 32'h18, 32'h1, 1'b0);
        check("tim_int_race", {63'd0, tim_int}, 64'd1);
        do_write("wr_tisr_clr", 32'h18, 32'h1, 1'b0);
        do_read("rd_tisr_clr", 32'h18, 32'h0, 1'b0);
        check("tim_int_clr", {63'd0, tim_int}, 64'd0);

        // Halt request / acknowledge
        do_write("wr_thcsr", 32'h1C, 32'hFFFF_FFFF, 1'b0);
        check("halt_req", {63'd0, halt_req}, 64'd1);
        halt_ack = 1'b1;
        do_read("rd_thcsr_ack", 32'h1C, 32'h3, 1'b0);
        halt_ack = 1'b0;

        // psel withdrawn during the wait state
        @(posedge sys_clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0BAD_0BAD;
        @(posedge sys_clk); #1; penable = 1'b1;
        @(posedge sys_clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge sys_clk); #1; seen = seen | pready; end
        check("abort_no_pready", {63'd0, seen}, 64'd0);
        do_read("rd_tcmp1_abort", 32'h10, 32'h3333_4444, 1'b0);

        // Reset during the wait state of a TCMP0 write
        @(posedge sys_clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hDEAD_0000;
        @(posedge sys_clk); #1; penable = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        check("rst_mid_pready", {63'd0, pready}, 64'd0);
        check("rst_mid_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge sys_clk); #1; sys_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge sys_clk); #1; seen = seen | pready; end
        check("rst_no_pready", {63'd0, seen}, 64'd0);
        do_read("rd_tcmp0_rst", 32'h0C, 32'hFFFF_FFFF, 1'b0);
        do_read("rd_tcr_rst", 32'h0, 32'h100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
